// File: rtl/udp_ts_split_mc.sv
`default_nettype none
// ============================================================================
// Module   : udp_ts_split_mc
// Purpose  : Multi-channel UDP-to-TS splitter. Parses a short address header
//            (dest IP + dest port), maps the port to a channel index, checks
//            every 188-byte TS packet for its sync byte and emits complete
//            packets as 32-bit words from a ping-pong buffer, tagged with
//            their channel.
// Ports    : clk        - system clock, rising edge
//            rst        - synchronous reset, active low
//            udp_din    - UDP payload byte
//            udp_din_en - byte valid, one contiguous run per datagram
//            ts_dout    - [32] start-of-packet, [31:0] four TS bytes (BE)
//            ts_dout_en - ts_dout valid
//            ts_ch      - channel of the packet being drained
//            err_sync   - pulse: packet dropped, bad sync byte
//            err_short  - pulse: datagram ended inside a packet
//            drop_dgram - pulse: datagram rejected at header stage
// Revision : 1.0 - initial release
// ============================================================================
module udp_ts_split_mc #(
  parameter int          HDR_LEN   = 6,
  parameter int          NUM_CH    = 4,
  parameter int          CH_W      = 2,
  parameter logic [15:0] PORT_BASE = 16'h1918,
  parameter bit          CHK_IP    = 1'b1,
  parameter logic [31:0] LOCAL_IP  = 32'hC0120808,
  parameter logic [7:0]  SYNC_BYTE = 8'h47
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      udp_din,
  input  logic            udp_din_en,
  output logic [32:0]     ts_dout,
  output logic            ts_dout_en,
  output logic [CH_W-1:0] ts_ch,
  output logic            err_sync,
  output logic            err_short,
  output logic            drop_dgram
);

  localparam int PKT_LEN = 188;
  localparam int WORDS   = PKT_LEN / 4;
  localparam int DEPTH   = 2 * WORDS;
  localparam int HDR_W   = (HDR_LEN - 1) * 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  // Input side
  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;        // header bytes accepted so far
  logic [HDR_W-1:0]  hdr_q, hdr_d;        // all header bytes but the last
  logic [CH_W-1:0]   ch_q, ch_d;          // channel of current datagram
  logic [7:0]        idx_q, idx_d;        // byte index inside TS packet
  logic              bad_q, bad_d;        // current packet failed sync check
  logic [23:0]       acc_q, acc_d;        // first three bytes of a word
  logic              wbank_q, wbank_d;
  logic [1:0]        full_q, full_d;      // bank holds a committed packet
  logic [2*CH_W-1:0] bank_ch_q, bank_ch_d;

  // Output side
  logic              rd_active_q, rd_active_d;
  logic              rd_bank_q, rd_bank_d;
  logic [5:0]        rd_idx_q, rd_idx_d;  // next word to emit
  logic [32:0]       ts_dout_q, ts_dout_d;
  logic              ts_dout_en_q, ts_dout_en_d;
  logic [CH_W-1:0]   ts_ch_q, ts_ch_d;
  logic              err_sync_q, err_sync_d;
  logic              err_short_q, err_short_d;
  logic              drop_q, drop_d;

  // Packet buffer: bank 0 at words 0..46, bank 1 at 47..93
  logic [31:0]       mem_q [DEPTH];
  logic              mem_we;
  logic [6:0]        mem_waddr;
  logic [31:0]       mem_wdata;
  logic [6:0]        rd_addr;
  logic [5:0]        rd_word;

  // Header decode, valid while the last header byte is on udp_din
  logic [HDR_LEN*8-1:0] hdr_full;
  logic [31:0]          hdr_ip;
  logic [15:0]          port_off;
  logic                 hdr_ok;

  always_comb begin
    hdr_full = {hdr_q, udp_din};
    hdr_ip   = hdr_full[HDR_LEN*8-1 -: 32];
    port_off = hdr_full[15:0] - PORT_BASE;   // wraps below base -> out of range
    hdr_ok   = (port_off < 16'(NUM_CH)) && (!CHK_IP || (hdr_ip == LOCAL_IP));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    ch_d        = ch_q;
    idx_d       = idx_q;
    bad_d       = bad_q;
    acc_d       = acc_q;
    wbank_d     = wbank_q;
    full_d      = full_q;
    bank_ch_d   = bank_ch_q;
    err_sync_d  = 1'b0;
    err_short_d = 1'b0;
    drop_d      = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = (wbank_q ? 7'(WORDS) : 7'd0) + {1'b0, idx_q[7:2]};
    mem_wdata   = {acc_q, udp_din};

    // Drain side first, so the fill side below can still mark its own bank.
    rd_active_d  = rd_active_q;
    rd_bank_d    = rd_bank_q;
    rd_idx_d     = rd_idx_q;
    rd_word      = rd_active_q ? rd_idx_q : 6'd0;
    rd_addr      = (rd_bank_q ? 7'(WORDS) : 7'd0) + {1'b0, rd_word};
    ts_dout_d    = 33'd0;
    ts_dout_en_d = 1'b0;
    ts_ch_d      = '0;
    if (rd_active_q) begin
      ts_dout_d    = {1'b0, mem_q[rd_addr]};
      ts_dout_en_d = 1'b1;
      ts_ch_d      = ts_ch_q;
      if (rd_idx_q == 6'(WORDS - 1)) begin
        rd_active_d       = 1'b0;
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        rd_idx_d = rd_idx_q + 6'd1;
      end
    end else if (full_q[rd_bank_q]) begin
      ts_dout_d    = {1'b1, mem_q[rd_addr]};
      ts_dout_en_d = 1'b1;
      ts_ch_d      = rd_bank_q ? bank_ch_q[2*CH_W-1:CH_W] : bank_ch_q[CH_W-1:0];
      rd_active_d  = 1'b1;
      rd_idx_d     = 6'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (udp_din_en) begin
          hdr_d   = {hdr_q[HDR_W-9:0], udp_din};
          cnt_d   = 8'd1;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (!udp_din_en) begin
          drop_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          hdr_d = {hdr_q[HDR_W-9:0], udp_din};
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(HDR_LEN - 1)) begin
            if (hdr_ok) begin
              ch_d    = port_off[CH_W-1:0];
              idx_d   = 8'd0;
              state_d = S_PAYLOAD;
            end else begin
              drop_d  = 1'b1;
              state_d = S_DISCARD;
            end
          end
        end
      end
      S_PAYLOAD: begin
        if (!udp_din_en) begin
          // A bad-sync packet has already been reported; no second pulse.
          err_short_d = (idx_q != 8'd0) && !bad_q;
          state_d     = S_IDLE;
        end else begin
          acc_d = {acc_q[15:0], udp_din};
          if (idx_q == 8'd0) begin
            bad_d      = (udp_din != SYNC_BYTE);
            err_sync_d = (udp_din != SYNC_BYTE);
          end
          mem_we = (idx_q[1:0] == 2'd3) && !bad_q;
          if (idx_q == 8'(PKT_LEN - 1)) begin
            idx_d = 8'd0;
            if (!bad_q) begin
              full_d[wbank_q] = 1'b1;
              if (wbank_q) bank_ch_d[2*CH_W-1:CH_W] = ch_q;
              else         bank_ch_d[CH_W-1:0]      = ch_q;
              wbank_d = ~wbank_q;
            end
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      default: begin // S_DISCARD
        if (!udp_din_en) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      hdr_q        <= '0;
      ch_q         <= '0;
      idx_q        <= 8'd0;
      bad_q        <= 1'b0;
      acc_q        <= 24'd0;
      wbank_q      <= 1'b0;
      full_q       <= 2'b00;
      bank_ch_q    <= '0;
      rd_active_q  <= 1'b0;
      rd_bank_q    <= 1'b0;
      rd_idx_q     <= 6'd0;
      ts_dout_q    <= 33'd0;
      ts_dout_en_q <= 1'b0;
      ts_ch_q      <= '0;
      err_sync_q   <= 1'b0;
      err_short_q  <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hdr_q        <= hdr_d;
      ch_q         <= ch_d;
      idx_q        <= idx_d;
      bad_q        <= bad_d;
      acc_q        <= acc_d;
      wbank_q      <= wbank_d;
      full_q       <= full_d;
      bank_ch_q    <= bank_ch_d;
      rd_active_q  <= rd_active_d;
      rd_bank_q    <= rd_bank_d;
      rd_idx_q     <= rd_idx_d;
      ts_dout_q    <= ts_dout_d;
      ts_dout_en_q <= ts_dout_en_d;
      ts_ch_q      <= ts_ch_d;
      err_sync_q   <= err_sync_d;
      err_short_q  <= err_short_d;
      drop_q       <= drop_d;
    end
  end

  assign ts_dout    = ts_dout_q;
  assign ts_dout_en = ts_dout_en_q;
  assign ts_ch      = ts_ch_q;
  assign err_sync   = err_sync_q;
  assign err_short  = err_short_q;
  assign drop_dgram = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_udp_ts_split_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_ts_split_mc
// Purpose  : Directed self-checking bench for udp_ts_split_mc. Drives whole
//            datagrams byte by byte, collects output words on the falling
//            edge and compares them against packet contents generated here.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udp_ts_split_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  udp_din = 8'd0;
  logic        udp_din_en = 1'b0;
  logic [32:0] ts_dout;
  logic        ts_dout_en;
  logic [1:0]  ts_ch;
  logic        err_sync;
  logic        err_short;
  logic        drop_dgram;

  int total = 0;
  int bad   = 0;

  int n_sync = 0, n_short = 0, n_drop = 0, idle_bad = 0;
  logic [34:0] cap [$];   // {ts_ch, ts_dout}

  always #5 clk = ~clk;

  udp_ts_split_mc dut (
    .clk        (clk),
    .rst        (rst),
    .udp_din    (udp_din),
    .udp_din_en (udp_din_en),
    .ts_dout    (ts_dout),
    .ts_dout_en (ts_dout_en),
    .ts_ch      (ts_ch),
    .err_sync   (err_sync),
    .err_short  (err_short),
    .drop_dgram (drop_dgram)
  );

  always @(negedge clk) begin
    if (ts_dout_en) cap.push_back({ts_ch, ts_dout});
    else if (ts_dout !== 33'd0 || ts_ch !== 2'd0) idle_bad++;
    if (err_sync)   n_sync++;
    if (err_short)  n_short++;
    if (drop_dgram) n_drop++;
  end

  function automatic logic [7:0] pkt_byte(input logic [7:0] sync, input logic [7:0] cnt, input int j);
    if (j == 0) return sync;
    if (j == 1) return 8'h10;
    if (j == 2) return 8'h01;
    if (j == 3) return cnt;
    return 8'(j - 3);
  endfunction

  function automatic logic [32:0] exp_word(input logic [7:0] cnt, input int i);
    logic [31:0] w;
    w = 32'd0;
    for (int k = 0; k < 4; k++) w = {w[23:0], pkt_byte(8'h47, cnt, 4*i + k)};
    return {(i == 0), w};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    udp_din    = b;
    udp_din_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_dgram(input logic [31:0] ip, input logic [15:0] port, input int npkts,
                            input int badpkt, input int trpkt, input int trlen);
    logic [47:0] h;
    int n;
    h = {ip, port};
    for (int i = 0; i < 6; i++) send_byte(h[47-8*i -: 8]);
    for (int p = 0; p < npkts; p++) begin
      n = (p == trpkt) ? trlen : 188;
      for (int j = 0; j < n; j++) send_byte(pkt_byte((p == badpkt) ? 8'h48 : 8'h47, 8'(p), j));
    end
    udp_din_en = 1'b0;
    udp_din    = 8'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_pkt(input int base, input logic [7:0] cnt, input logic [1:0] ch);
    int mism;
    mism = 0;
    if (cap.size() < base + 47) begin
      chk("pkt_present", 64'(cap.size()), 64'(base + 47));
      return;
    end
    chk("word0",  64'(cap[base][32:0]),    64'(exp_word(cnt, 0)));
    chk("word1",  64'(cap[base+1][32:0]),  64'(exp_word(cnt, 1)));
    chk("word46", 64'(cap[base+46][32:0]), 64'(exp_word(cnt, 46)));
    for (int i = 0; i < 47; i++)
      if (cap[base+i] !== {ch, exp_word(cnt, i)}) mism++;
    chk("pkt_words_ch", 64'(mism), 64'd0);
  endtask

  initial begin
    int b0, s0, h0, d0;
    logic [7:0] dcnt [7];

    // Reset state
    rst = 1'b0;
    idle(3);
    chk("rst_en",   64'(ts_dout_en), 64'd0);
    chk("rst_dout", 64'(ts_dout),    64'd0);
    chk("rst_ch",   64'(ts_ch),      64'd0);
    chk("rst_err",  64'({err_sync, err_short, drop_dgram}), 64'd0);
    rst = 1'b1;
    idle(2);

    // Eight good packets, channel 0
    b0 = cap.size(); s0 = n_sync; h0 = n_short; d0 = n_drop;
    send_dgram(32'hC0120808, 16'h1918, 8, -1, -1, 0);
    idle(60);
    chk("a_count", 64'(cap.size() - b0), 64'd376);
    for (int p = 0; p < 8; p++) chk_pkt(b0 + 47*p, 8'(p), 2'd0);
    chk("a_pulses", 64'((n_sync - s0) + (n_short - h0) + (n_drop - d0)), 64'd0);

    // Six packets, channel 1
    #800;
    b0 = cap.size();
    send_dgram(32'hC0120808, 16'h1919, 6, -1, -1, 0);
    idle(60);
    chk("b_count", 64'(cap.size() - b0), 64'd282);
    for (int p = 0; p < 6; p++) chk_pkt(b0 + 47*p, 8'(p), 2'd1);

    // Port out of range
    b0 = cap.size(); d0 = n_drop;
    send_dgram(32'hC0120808, 16'h1920, 2, -1, -1, 0);
    idle(60);
    chk("port_drop",  64'(n_drop - d0), 64'd1);
    chk("port_words", 64'(cap.size() - b0), 64'd0);

    // IP mismatch
    b0 = cap.size(); d0 = n_drop;
    send_dgram(32'hC0120809, 16'h1918, 2, -1, -1, 0);
    idle(60);
    chk("ip_drop",  64'(n_drop - d0), 64'd1);
    chk("ip_words", 64'(cap.size() - b0), 64'd0);

    // Datagram that ends inside the header
    d0 = n_drop;
    send_byte(8'hC0); send_byte(8'h12); send_byte(8'h08);
    udp_din_en = 1'b0;
    idle(5);
    chk("short_hdr_drop", 64'(n_drop - d0), 64'd1);

    // Packet 3 with bad sync byte
    b0 = cap.size(); s0 = n_sync; h0 = n_short;
    send_dgram(32'hC0120808, 16'h1918, 8, 3, -1, 0);
    idle(60);
    chk("sync_pulse", 64'(n_sync - s0), 64'd1);
    chk("sync_short", 64'(n_short - h0), 64'd0);
    chk("sync_count", 64'(cap.size() - b0), 64'd329);
    dcnt = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd7};
    for (int p = 0; p < 7; p++) chk_pkt(b0 + 47*p, dcnt[p], 2'd0);

    // Truncated in packet 2, followed one idle cycle later by a new datagram
    b0 = cap.size(); h0 = n_short; s0 = n_sync;
    send_dgram(32'hC0120808, 16'h1918, 3, -1, 2, 100);
    @(posedge clk); #1;
    send_dgram(32'hC0120808, 16'h1919, 1, -1, -1, 0);
    idle(60);
    chk("trunc_short", 64'(n_short - h0), 64'd1);
    chk("trunc_sync",  64'(n_sync - s0), 64'd0);
    chk("trunc_count", 64'(cap.size() - b0), 64'd141);
    chk_pkt(b0,      8'd0, 2'd0);
    chk_pkt(b0 + 47, 8'd1, 2'd0);
    chk_pkt(b0 + 94, 8'd0, 2'd1);

    // Latency, then reset while word 20 is on the output
    b0 = cap.size();
    send_dgram(32'hC0120808, 16'h191A, 1, -1, -1, 0);
    chk("lat_early", 64'(ts_dout_en), 64'd0);
    @(posedge clk); #1;
    chk("lat_en",    64'(ts_dout_en), 64'd1);
    chk("lat_word0", 64'(ts_dout),    64'(exp_word(8'd0, 0)));
    chk("lat_ch",    64'(ts_ch),      64'd2);
    repeat (20) @(posedge clk);
    #1;
    chk("word20", 64'(ts_dout), 64'(exp_word(8'd0, 20)));
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("rst_mid_en",   64'(ts_dout_en), 64'd0);
    chk("rst_mid_dout", 64'(ts_dout),    64'd0);
    idle(60);
    chk("rst_mid_words", 64'(cap.size() - b0), 64'd21);

    b0 = cap.size();
    send_dgram(32'hC0120808, 16'h191B, 1, -1, -1, 0);
    idle(60);
    chk("post_rst_count", 64'(cap.size() - b0), 64'd47);
    chk_pkt(b0, 8'd0, 2'd3);

    chk("idle_outputs_zero", 64'(idle_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/udp_ts_split_mc.md
Name: udp_ts_split_mc

Overview:
Parametrised multi-channel successor to the UDP-to-TS splitter. It takes a byte-wide UDP payload stream carrying a short address header and N×188-byte MPEG-TS packets. It validates the header and each packet's sync byte, maps the destination port to a channel index, and emits whole TS packets as 32-bit words tagged with that channel. It sits between the UDP receive path and the multi-TS merge logic.

Parameters:
HDR_LEN, 6, header bytes before the first TS packet (bytes 0-3 dest IP, bytes HDR_LEN-2..HDR_LEN-1 dest port, big-endian).
NUM_CH, 4, number of valid channels; channel = port - PORT_BASE.
CH_W, 2, width of channel index (ceil log2 NUM_CH, min 1).
PORT_BASE, 16'h1918, port mapped to channel 0.
CHK_IP, 1, 1 = drop datagram unless dest IP == LOCAL_IP.
LOCAL_IP, 32'hC0120808, accepted destination IP (192.18.8.8).
SYNC_BYTE, 8'h47, required first byte of every TS packet.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
udp_din  in  8  UDP byte
udp_din_en  in  1  byte valid; a datagram is one contiguous run of en=1
ts_dout  out  33  [32] = start-of-packet flag, [31:0] = 4 TS bytes, first byte in [31:24]
ts_dout_en  out  1  ts_dout valid
ts_ch  out  CH_W  channel of current output packet
err_sync  out  1  1-cycle pulse: TS packet rejected for bad sync byte
err_short  out  1  1-cycle pulse: datagram ended inside a TS packet
drop_dgram  out  1  1-cycle pulse: datagram rejected (short header, IP mismatch, port out of range)

Behaviour:
- Reset (rst=0 sampled): all outputs 0, FSM to IDLE, both buffer banks empty, in-flight output packet abandoned (no further words).
- Input FSM states IDLE, HDR, PAYLOAD, DISCARD; byte counter counts accepted bytes.
- IDLE: en=1 -> store byte as header byte 0, go HDR.
- HDR: store bytes; on header byte HDR_LEN-1, evaluate IP (if CHK_IP) and channel = port-PORT_BASE (unsigned 16-bit; valid if < NUM_CH). Pass -> PAYLOAD, packet index 0. Fail -> drop_dgram pulse next cycle, go DISCARD. en=0 in HDR -> drop_dgram pulse, IDLE.
- PAYLOAD: packet byte index 0..187; bytes packed big-endian into 32-bit words written to current ping-pong bank (47 words).
  - Index 0 != SYNC_BYTE: err_sync pulse, consume remaining 187 bytes without committing.
  - Index 187 of good packet: commit bank (tag with channel), switch write bank, index to 0.
  - en=0 at index 0: datagram ends cleanly, IDLE, no pulse. en=0 at index 1..187: discard partial, err_short pulse, IDLE.
- DISCARD: ignore bytes until en=0, then IDLE.
- en rising in the cycle immediately after falling starts a new datagram normally.
- Output: committed bank drains 1 word/cycle, 47 consecutive cycles, ts_dout_en=1; word 0 has ts_dout[32]=1, others 0; ts_ch constant across the packet. Idle: ts_dout=0, ts_ch=0.
- Latency: if byte 187 is sampled at edge N, word 0 is valid after edge N+1.
- Two banks: input needs 188 cycles/packet, drain takes 47, so no overflow at 1 byte/cycle. Back-to-back packets across datagrams of different channels keep per-packet tags.
- Only one error pulse per event; pulses do not affect already committed packets.

Test Plan:
- Header C0 12 08 08 19 18, 8 packets (47 10 01 cnt, then 01..B8) -> 8×47 words on ts_ch=0; word0 = 1_47100100 + cnt, word1 = 0_01020304, word46 = 0_B5B6B7B8; no error pulses.
- Header port 19 19, 6 packets sent 800 ns after the first datagram -> 282 words, ts_ch=1, SOP on each 47th.
- Port 19 20 (channel 8 ≥ NUM_CH) or IP C0 12 08 09 -> one drop_dgram pulse, ts_dout_en stays 0 for the whole datagram.
- 8-packet datagram with packet 3 sync byte 48 -> one err_sync pulse, exactly 7 packets output, cnt values 0,1,2,4..7.
- en drops after byte 100 of packet 2 -> packet 1 output complete, err_short pulse, no SOP for packet 2; next datagram is unaffected.
- rst=0 for one cycle during word 20 of output -> ts_dout_en=0 after that edge, no remaining words; a following datagram outputs correctly.
